// File: rtl/ccff_pkg.sv
// Shared types and constants for the ccff bitstream loader.
// Readback is enabled by defining CCFF_READBACK_EN.
package ccff_pkg;

  localparam int unsigned CHAIN_LEN_DEFAULT = 16;
  localparam int unsigned WORD_W_DEFAULT    = 8;
  localparam logic [7:0]  CRC8_POLY         = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // One serial CRC-8 step, MSB-first feedback.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Serial CRC-8 accumulator, one bit per enabled cycle.
module ccff_crc8
  import ccff_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = crc8_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ccff_loader.sv
// Loads a word-wide bitstream serially into a ccff chain, MSB first.
// Optional CRC-8 readback/recirculation of the chain under CCFF_READBACK_EN.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int unsigned WORD_W    = WORD_W_DEFAULT,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int unsigned BUF_CW = $clog2(WORD_W + 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic [BUF_CW-1:0]   buf_cnt_q, buf_cnt_d;
  logic [CNT_W-1:0]    bit_count_q, bit_count_d;
  logic [CNT_W-1:0]    accepted_q, accepted_d;

  logic                shift_load;
  logic                last_load;
  logic                ready;
  logic                accept;
  logic                crc_clear;
  logic [31:0]         remaining;
  logic [BUF_CW-1:0]   take_n;

  always_comb begin
    shift_load = (state_q == ST_LOAD) && (buf_cnt_q != '0);
    last_load  = shift_load && (bit_count_q == CNT_W'(CHAIN_LEN - 1));
    remaining  = CHAIN_LEN - 32'(accepted_q);
    // Ready also while the last buffered bit shifts out, so words chain without a bubble.
    ready      = (state_q == ST_LOAD) && (buf_cnt_q <= BUF_CW'(1)) && (remaining != 0);
    accept     = ready && cfg_valid;
    take_n     = (remaining >= WORD_W) ? BUF_CW'(WORD_W) : BUF_CW'(remaining);
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_cnt_d   = buf_cnt_q;
    bit_count_d = bit_count_q;
    accepted_d  = accepted_q;
    crc_clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          buf_d       = '0;
          buf_cnt_d   = '0;
          bit_count_d = '0;
          accepted_d  = '0;
          crc_clear   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (shift_load) begin
          buf_d       = buf_q << 1;
          buf_cnt_d   = buf_cnt_q - BUF_CW'(1);
          bit_count_d = bit_count_q + CNT_W'(1);
        end
        if (accept) begin
          buf_d      = cfg_data;
          buf_cnt_d  = take_n;
          accepted_d = accepted_q + CNT_W'(take_n);
        end
        // Final shift: drop any unused tail bits of a partial last word.
        if (last_load) begin
          buf_d     = '0;
          buf_cnt_d = '0;
`ifdef CCFF_READBACK_EN
          state_d     = ST_VERIFY;
          bit_count_d = '0;
`else
          state_d     = ST_DONE;
`endif
        end
      end
`ifdef CCFF_READBACK_EN
      ST_VERIFY: begin
        bit_count_d = bit_count_q + CNT_W'(1);
        if (bit_count_q == CNT_W'(CHAIN_LEN - 1)) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      buf_cnt_q   <= '0;
      bit_count_q <= '0;
      accepted_q  <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_cnt_q   <= buf_cnt_d;
      bit_count_q <= bit_count_d;
      accepted_q  <= accepted_d;
    end
  end

`ifdef CCFF_READBACK_EN
  logic       in_verify;
  logic       verify_last;
  logic [7:0] crc_load;
  logic [7:0] crc_rb;
  logic       error_q, error_d;

  assign in_verify   = (state_q == ST_VERIFY);
  assign verify_last = in_verify && (bit_count_q == CNT_W'(CHAIN_LEN - 1));

  ccff_crc8 u_crc_load (
    .clk    (prog_clk),
    .rst_n  (prog_reset),
    .enable (shift_load),
    .clear  (crc_clear),
    .bit_in (ccff_head),
    .crc    (crc_load)
  );

  ccff_crc8 u_crc_rb (
    .clk    (prog_clk),
    .rst_n  (prog_reset),
    .enable (in_verify),
    .clear  (crc_clear),
    .bit_in (ccff_tail),
    .crc    (crc_rb)
  );

  // Fold the final tail bit in combinationally so error is valid during the done pulse.
  always_comb begin
    error_d = error_q;
    if (crc_clear) begin
      error_d = 1'b0;
    end else if (verify_last) begin
      error_d = error_q | (crc_load != crc8_step(crc_rb, ccff_tail));
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error         = error_q;
  assign ccff_head     = in_verify ? ccff_tail : buf_q[WORD_W-1];
  assign ccff_shift_en = shift_load | in_verify;
  assign busy          = (state_q == ST_LOAD) || in_verify;
`else
  logic unused_tail;
  assign unused_tail   = ccff_tail ^ crc_clear;
  assign error         = 1'b0;
  assign ccff_head     = buf_q[WORD_W-1];
  assign ccff_shift_en = shift_load;
  assign busy          = (state_q == ST_LOAD);
`endif

  assign cfg_ready = ready;
  assign done      = (state_q == ST_DONE);
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: two instances (16-flop and 12-flop chains) with chain models.
module tb_ccff_loader;

`ifdef CCFF_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  localparam int P_IDLE = 0, P_LOAD = 1, P_VERIFY = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_s   [2];
  logic [7:0]  data_s    [2];
  logic        valid_s   [2];
  logic        ready_s   [2];
  logic        head_s    [2];
  logic        tail_s    [2];
  logic        shen_s    [2];
  logic        busy_s    [2];
  logic        done_s    [2];
  logic        error_s   [2];
  logic [15:0] bc_s      [2];
  logic        inj_s     [2];

  logic [15:0] chain0 = '0;
  logic [11:0] chain1 = '0;

  int checks = 0;
  int failures = 0;

  ccff_loader #(.CHAIN_LEN(16), .WORD_W(8), .CNT_W(16)) u_dut0 (
    .prog_clk(clk), .prog_reset(rst_n), .start(start_s[0]), .cfg_data(data_s[0]),
    .cfg_valid(valid_s[0]), .cfg_ready(ready_s[0]), .ccff_head(head_s[0]),
    .ccff_tail(tail_s[0]), .ccff_shift_en(shen_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .error(error_s[0]), .bit_count(bc_s[0])
  );

  ccff_loader #(.CHAIN_LEN(12), .WORD_W(8), .CNT_W(16)) u_dut1 (
    .prog_clk(clk), .prog_reset(rst_n), .start(start_s[1]), .cfg_data(data_s[1]),
    .cfg_valid(valid_s[1]), .cfg_ready(ready_s[1]), .ccff_head(head_s[1]),
    .ccff_tail(tail_s[1]), .ccff_shift_en(shen_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .error(error_s[1]), .bit_count(bc_s[1])
  );

  // External chains: head enters at bit 0, tail is the top bit.
  always @(posedge clk) begin
    if (shen_s[0]) chain0 <= {chain0[14:0], head_s[0]} ^ (inj_s[0] ? 16'h0010 : 16'h0000);
    if (shen_s[1]) chain1 <= {chain1[10:0], head_s[1]} ^ (inj_s[1] ? 12'h010 : 12'h000);
  end
  assign tail_s[0] = chain0[15];
  assign tail_s[1] = chain1[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc_upd(input logic [7:0] c, input bit b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  // Reference model state
  int  len [2] = '{16, 12};
  int  ph  [2] = '{0, 0};
  int  acc [2] = '{0, 0};
  int  sh  [2] = '{0, 0};
  int  bcm [2] = '{0, 0};
  int  vc  [2] = '{0, 0};
  bit  merr[2] = '{0, 0};
  bit  lbits [2][64];
  logic [7:0] lcrc[2] = '{8'h00, 8'h00};
  logic [7:0] rcrc[2] = '{8'h00, 8'h00};

  // Observations used by per-test literal checks
  int          cyc = 0;
  logic [63:0] cap  [2] = '{64'd0, 64'd0};
  int          capn [2] = '{0, 0};
  int          stalls [2] = '{0, 0};
  int          dones [2] = '{0, 0};
  int          last_sh_cyc [2] = '{0, 0};
  int          done_cyc [2] = '{0, 0};
  logic        err_at_done [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      automatic bit shifting = (ph[k] == P_LOAD) && (acc[k] > sh[k]);
      automatic bit e_ready = (ph[k] == P_LOAD) && (acc[k] - sh[k] <= 1) && (acc[k] < len[k]);
      automatic bit e_shen = shifting || (ph[k] == P_VERIFY);
      automatic bit e_head = shifting ? lbits[k][sh[k]] : ((ph[k] == P_VERIFY) ? tail_s[k] : 1'b0);
      automatic string s = (k == 0) ? "c16" : "c12";
      chk({s, "_ready"}, ready_s[k], e_ready);
      chk({s, "_shift_en"}, shen_s[k], e_shen);
      chk({s, "_head"}, head_s[k], e_head);
      chk({s, "_busy"}, busy_s[k], (ph[k] == P_LOAD) || (ph[k] == P_VERIFY));
      chk({s, "_done"}, done_s[k], ph[k] == P_DONE);
      chk({s, "_error"}, error_s[k], merr[k]);
      chk({s, "_bit_count"}, bc_s[k], bcm[k]);

      if (ph[k] == P_LOAD && shen_s[k]) begin
        cap[k] = {cap[k][62:0], head_s[k]};
        capn[k]++;
        last_sh_cyc[k] = cyc;
      end else if (ph[k] == P_LOAD && capn[k] > 0 && !shen_s[k] && acc[k] < len[k]) begin
        stalls[k]++;
      end
      if (done_s[k]) begin
        dones[k]++;
        done_cyc[k] = cyc;
        err_at_done[k] = error_s[k];
      end

      if (!rst_n) begin
        ph[k] = P_IDLE; acc[k] = 0; sh[k] = 0; bcm[k] = 0; merr[k] = 1'b0;
      end else begin
        case (ph[k])
          P_IDLE: if (start_s[k]) begin
            ph[k] = P_LOAD; acc[k] = 0; sh[k] = 0; bcm[k] = 0; merr[k] = 1'b0;
            lcrc[k] = 8'h00; rcrc[k] = 8'h00;
          end
          P_LOAD: begin
            if (shifting) begin
              lcrc[k] = crc_upd(lcrc[k], lbits[k][sh[k]]);
              sh[k]++; bcm[k]++;
            end
            if (e_ready && valid_s[k]) begin
              automatic int n = (len[k] - acc[k] > 8) ? 8 : len[k] - acc[k];
              automatic logic [7:0] w = data_s[k];
              for (int i = 0; i < n; i++) lbits[k][acc[k] + i] = w[7 - i];
              acc[k] += n;
            end
            if (shifting && sh[k] == len[k]) begin
              if (RB) begin ph[k] = P_VERIFY; bcm[k] = 0; vc[k] = 0; end
              else ph[k] = P_DONE;
            end
          end
          P_VERIFY: begin
            rcrc[k] = crc_upd(rcrc[k], tail_s[k]);
            vc[k]++; bcm[k]++;
            if (vc[k] == len[k]) begin
              ph[k] = P_DONE;
              merr[k] = (rcrc[k] != lcrc[k]);
            end
          end
          default: ph[k] = P_IDLE;
        endcase
      end
    end
  end

  task automatic clear_obs(input int k);
    cap[k] = '0; capn[k] = 0; stalls[k] = 0; dones[k] = 0;
  endtask

  task automatic pulse_start(input int k);
    start_s[k] = 1'b1;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
  endtask

  // Leaves cfg_valid high after the accepting edge so a following call is back-to-back.
  task automatic send_word(input int k, input logic [7:0] w);
    bit got = 1'b0;
    int n = 0;
    data_s[k] = w;
    valid_s[k] = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      got = ready_s[k];
      @(posedge clk); #1;
      n++;
    end
    if (!got) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    while (!done_s[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done_s[k]) chk("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 0; data_s[k] = '0; valid_s[k] = 0; inj_s[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy_s[0], 0);
    chk("reset_ready", ready_s[0], 0);
    chk("reset_bit_count", bc_s[0], 0);
    @(posedge clk); #1;

    // Back-to-back words on the 16-flop chain
    clear_obs(0);
    pulse_start(0);
    send_word(0, 8'hA5);
    send_word(0, 8'h3C);
    valid_s[0] = 0;
    wait_done(0);
    chk("b2b_bits", cap[0][15:0], 16'hA53C);
    chk("b2b_nbits", capn[0], 16);
    chk("b2b_stalls", stalls[0], 0);
    chk("b2b_done_gap", done_cyc[0] - last_sh_cyc[0], RB ? 17 : 1);
    chk("b2b_done_count", dones[0], 1);
    chk("b2b_chain", chain0, 16'hA53C);
    chk("b2b_error", err_at_done[0], 0);

    // Three-cycle gap between words
    clear_obs(0);
    pulse_start(0);
    send_word(0, 8'hA5);
    valid_s[0] = 0;
    repeat (10) @(posedge clk);
    #1;
    send_word(0, 8'h3C);
    valid_s[0] = 0;
    wait_done(0);
    chk("stall_bits", cap[0][15:0], 16'hA53C);
    chk("stall_cycles", stalls[0], 3);
    chk("stall_done_count", dones[0], 1);

    // 12-flop chain: partial final word
    clear_obs(1);
    pulse_start(1);
    send_word(1, 8'hF0);
    send_word(1, 8'hAB);
    valid_s[1] = 0;
    wait_done(1);
    chk("c12_bits", cap[1][11:0], 12'hF0A);
    chk("c12_nbits", capn[1], 12);
    chk("c12_chain", chain1, 12'hF0A);
    chk("c12_done_count", dones[1], 1);

`ifdef CCFF_READBACK_EN
    // Corrupt one chain bit mid-verify
    clear_obs(0);
    pulse_start(0);
    send_word(0, 8'hA5);
    send_word(0, 8'h3C);
    valid_s[0] = 0;
    for (int n = 0; n < 100 && ph[0] != P_VERIFY; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1 inj_s[0] = 1'b1;
    @(posedge clk); #1 inj_s[0] = 1'b0;
    wait_done(0);
    chk("inject_error", err_at_done[0], 1);
    chk("inject_done_count", dones[0], 1);
`endif

    // Reset in the middle of a load
    clear_obs(0);
    pulse_start(0);
    send_word(0, 8'hA5);
    valid_s[0] = 0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("abort_busy", busy_s[0], 0);
    chk("abort_shift_en", shen_s[0], 0);
    chk("abort_bit_count", bc_s[0], 0);
    chk("abort_shifts_before", capn[0], 5);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", dones[0], 0);

    // Second start while loading is ignored
    clear_obs(0);
    pulse_start(0);
    send_word(0, 8'hA5);
    valid_s[0] = 0;
    pulse_start(0);
    send_word(0, 8'h3C);
    valid_s[0] = 0;
    wait_done(0);
    repeat (20) @(posedge clk);
    #1;
    chk("restart_bits", cap[0][15:0], 16'hA53C);
    chk("restart_nbits", capn[0], 16);
    chk("restart_done_count", dones[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
